viterbi_seq_ctrl: RTL and testbench
===================================

Name: viterbi_seq_ctrl

Overview:
Parametrised frame-based sequencer for the convolutional encoder / Viterbi decoder datapath. It drives the same unit enables: o_en_ce, o_en_s, o_en_bm, o_en_acs, o_en_td and o_en_t. It adds a frame-length counter, a sliding traceback window of configurable depth, valid/ready handshakes on both sides, and an end-of-frame flush. It sits between the input symbol FIFO, the codec datapath and the decoded-bit sink.

Parameters:
TB_DEPTH, 32, traceback window depth in symbols; must be at least 2.
FRAME_W, 16, width of the frame-length and symbol counters.
TB_CW, $clog2(TB_DEPTH+1), width of the window and flush counters.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
en  in  1  global enable; 0 freezes the state and counters and forces all o_en_* to 0
i_constr_len  in  2  constraint-length code from the package (CL3/CL5/CL7/CL9)
i_mode_sel  in  1  MODE_ENCODE or MODE_DECODE
i_start  in  1  start-of-frame pulse; sampled only in IDLE
i_frame_len  in  FRAME_W  symbols in the frame; latched on start
i_in_valid  in  1  upstream symbol available
i_cal_done  in  1  branch-metric precalculation finished
i_out_ready  in  1  downstream can accept an output bit
o_in_ready  out  1  symbol accept handshake
o_en_ce, o_en_s, o_en_bm, o_en_acs, o_en_td, o_en_t  out  1 each  unit enables
o_busy  out  1  high when state is not IDLE
o_done  out  1  one-cycle pulse at frame completion
o_err  out  1  one-cycle pulse when started with i_frame_len == 0

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE, all counters 0, all outputs 0.
- Outputs are combinational from state, counters and inputs. Every output is 0 when en=0.
- acc = i_in_valid & o_in_ready & en. One symbol is consumed per acc cycle, and sym_cnt increments by 1.
- States and transitions:
  - IDLE: o_in_ready=0.
    - i_start with frame_len=0: pulse o_err, stay in IDLE.
    - i_start, encode mode: go to ENC.
    - i_start, decode mode: go to BMPRE.
    - i_start at any other time is ignored.
  - ENC: o_in_ready=i_out_ready; o_en_ce=acc. Accepting the last symbol (sym_cnt==frame_len-1) moves to DONE.
  - BMPRE: o_en_ce=1, o_en_bm=1, o_in_ready=0. On i_cal_done: CL3 goes to DIRECT, otherwise FILL.
  - FILL: o_in_ready=1; o_en_s, o_en_bm, o_en_acs and o_en_td equal acc; win_cnt++ on acc.
    - Last frame symbol accepted: go to FLUSH with flush_cnt=win_cnt+1.
    - Otherwise, acc with win_cnt==TB_DEPTH-1: go to STREAM.
  - STREAM: o_in_ready=i_out_ready; the FILL enables plus o_en_t equal acc. One decoded bit is produced per accepted symbol. Last symbol accepted: go to FLUSH with flush_cnt=TB_DEPTH.
  - FLUSH: o_in_ready=0; o_en_td=1; o_en_t=i_out_ready. flush_cnt decrements when o_en_t=1; reaching 0 goes to DONE.
  - DIRECT (CL3, no survivor memory): o_in_ready=i_out_ready; o_en_s, o_en_bm and o_en_acs equal acc; o_en_t equals the registered acc of the previous cycle (1-cycle lag). After the last acc there is one extra cycle with o_en_t=1, then DONE.
  - DONE: o_done=1 for one cycle, then IDLE with counters cleared.
- Boundary cases:
  - frame_len < TB_DEPTH: FLUSH is entered from FILL and drains exactly frame_len bits.
  - frame_len == TB_DEPTH: the last accept in FILL goes to FLUSH, not STREAM.
  - i_out_ready low in STREAM: input stalls; no enables fire.
  - en low mid-frame: state and counters hold; resumes on the same cycle en returns.
  - rst low mid-frame: returns to IDLE next edge; no o_done.
  - Counters are unsigned; sym_cnt never exceeds frame_len.

Optional Feature:
VITERBI_ABORT_EN
- Defined: adds input i_abort.
  - i_abort=1 in any non-IDLE state returns to IDLE on the next edge and clears the counters; all enables are 0 in that cycle; no o_done.
  - Abort takes priority over every other transition.
- Undefined: the port does not exist; a frame always runs to DONE.

Decomposition:
- Package viterbi_pkg: state enum typedef (IDLE, ENC, BMPRE, FILL, STREAM, FLUSH, DIRECT, DONE), constraint-length codes, MODE_ENCODE/MODE_DECODE constants.
- One sub-module, viterbi_win_cnt: loadable up/down counter of width TB_CW with inc, dec, load and zero/terminal flags. Used for both win_cnt and flush_cnt.

Test Plan:
- TB_DEPTH=8, decode CL5, frame_len=20, valid/ready always high:
  - i_cal_done after 4 cycles.
  - FILL for 8 cycles, then STREAM with 12 o_en_t pulses, then FLUSH with 8 o_en_t pulses.
  - o_done exactly once; 20 o_en_t pulses total.
- Encode, frame_len=4, i_out_ready low for 2 cycles mid-frame: exactly 4 o_en_ce pulses, none while stalled; then DONE.
- Decode CL3, frame_len=5: 5 acc cycles; o_en_t pulses lag acc by 1 cycle; 5 pulses; then DONE.
- TB_DEPTH=8, frame_len=3: FILL goes straight to FLUSH; 3 o_en_t pulses; o_done.
- Frame_len=0: o_err pulses and the block stays in IDLE. rst low during STREAM: IDLE next cycle, all outputs 0, no o_done.
- VITERBI_ABORT_EN defined: i_abort in FLUSH gives IDLE next cycle and no o_done; a subsequent frame with frame_len=10 completes normally.

Source files
------------

// File: rtl/viterbi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : viterbi_pkg
//  Description : Shared types and codes for the Viterbi codec frame sequencer:
//                sequencer state enum, constraint-length codes, mode codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package viterbi_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ENC    = 3'd1,
        BMPRE  = 3'd2,
        FILL   = 3'd3,
        STREAM = 3'd4,
        FLUSH  = 3'd5,
        DIRECT = 3'd6,
        DONE   = 3'd7
    } state_t;

    // Constraint-length codes
    localparam logic [1:0] CL3 = 2'd0;
    localparam logic [1:0] CL5 = 2'd1;
    localparam logic [1:0] CL7 = 2'd2;
    localparam logic [1:0] CL9 = 2'd3;

    // Operating mode codes
    localparam logic MODE_ENCODE = 1'b0;
    localparam logic MODE_DECODE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/viterbi_seq_ctrl_win_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : viterbi_win_cnt
//  Description : Loadable up/down counter with zero and terminal-count flags.
//                Priority: clear > load > increment > decrement.
//  Revision    : 1.0 - initial release
// ============================================================================
module viterbi_win_cnt
    import viterbi_pkg::*;
#(
    parameter int W    = 6,
    parameter int TERM = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o,
    output logic         term_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count selection
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec_i) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register, frozen while the enable is low
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);
    assign term_o = (cnt_q == W'(TERM));

endmodule
`default_nettype wire

// File: rtl/viterbi_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : viterbi_seq_ctrl
//  Description : Frame sequencer for the convolutional encoder / Viterbi
//                decoder datapath. Tracks frame length, a sliding traceback
//                window and an end-of-frame flush, and drives unit enables.
//                Optional macro VITERBI_ABORT_EN adds the i_abort input.
//  Revision    : 1.0 - initial release
// ============================================================================
module viterbi_seq_ctrl
    import viterbi_pkg::*;
#(
    parameter int TB_DEPTH = 32,
    parameter int FRAME_W  = 16,
    parameter int TB_CW    = $clog2(TB_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         i_constr_len,
    input  logic               i_mode_sel,
    input  logic               i_start,
    input  logic [FRAME_W-1:0] i_frame_len,
    input  logic               i_in_valid,
    input  logic               i_cal_done,
    input  logic               i_out_ready,
`ifdef VITERBI_ABORT_EN
    input  logic               i_abort,
`endif
    output logic               o_in_ready,
    output logic               o_en_ce,
    output logic               o_en_s,
    output logic               o_en_bm,
    output logic               o_en_acs,
    output logic               o_en_td,
    output logic               o_en_t,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err
);

    state_t               state_q, state_d;
    logic [FRAME_W-1:0]   sym_cnt_q, sym_cnt_d;
    logic [FRAME_W-1:0]   frame_len_q, frame_len_d;
    logic                 cl3_q, cl3_d;
    logic                 acc_q, acc_d;

    logic                 w_abort, w_run, w_in_ready, w_acc, w_all_in, w_last;
    logic                 w_win_clr, w_win_inc;
    logic                 w_fl_clr, w_fl_load, w_fl_dec;
    logic [TB_CW-1:0]     w_fl_val;
    logic [TB_CW-1:0]     w_win_cnt, w_fl_cnt;
    logic                 w_win_zero, w_win_term, w_fl_zero, w_fl_term;
    logic                 w_unused_flags;

`ifdef VITERBI_ABORT_EN
    assign w_abort = en & i_abort & (state_q != IDLE);
`else
    assign w_abort = 1'b0;
`endif

    // An aborting cycle behaves like a disabled cycle for every enable
    assign w_run    = en & ~w_abort;
    assign w_all_in = (sym_cnt_q == frame_len_q);
    assign w_in_ready = w_run & (
        ((state_q == ENC) || (state_q == STREAM)) ? i_out_ready :
        (state_q == FILL)                         ? 1'b1 :
        (state_q == DIRECT)                       ? (i_out_ready & ~w_all_in) :
                                                    1'b0);
    assign w_acc  = i_in_valid & w_in_ready;
    assign w_last = w_acc & (sym_cnt_q == (frame_len_q - FRAME_W'(1)));

    viterbi_win_cnt #(.W(TB_CW), .TERM(TB_DEPTH - 1)) u_win_cnt (
        .clk        (clk),
        .rst        (rst),
        .en_i       (en),
        .clr_i      (w_win_clr),
        .load_i     (1'b0),
        .load_val_i ('0),
        .inc_i      (w_win_inc),
        .dec_i      (1'b0),
        .cnt_o      (w_win_cnt),
        .zero_o     (w_win_zero),
        .term_o     (w_win_term)
    );

    // Flush counter terminal value of 1 marks the final traceback bit
    viterbi_win_cnt #(.W(TB_CW), .TERM(1)) u_flush_cnt (
        .clk        (clk),
        .rst        (rst),
        .en_i       (en),
        .clr_i      (w_fl_clr),
        .load_i     (w_fl_load),
        .load_val_i (w_fl_val),
        .inc_i      (1'b0),
        .dec_i      (w_fl_dec),
        .cnt_o      (w_fl_cnt),
        .zero_o     (w_fl_zero),
        .term_o     (w_fl_term)
    );

    assign w_unused_flags = ^{w_win_zero, w_fl_zero, w_fl_cnt};

    // State and frame registers; everything holds while en is low
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            sym_cnt_q   <= '0;
            frame_len_q <= '0;
            cl3_q       <= 1'b0;
            acc_q       <= 1'b0;
        end else if (en) begin
            state_q     <= state_d;
            sym_cnt_q   <= sym_cnt_d;
            frame_len_q <= frame_len_d;
            cl3_q       <= cl3_d;
            acc_q       <= acc_d;
        end
    end

    // Next-state, frame bookkeeping and window/flush counter control
    always_comb begin
        state_d     = state_q;
        frame_len_d = frame_len_q;
        cl3_d       = cl3_q;
        sym_cnt_d   = w_acc ? (sym_cnt_q + FRAME_W'(1)) : sym_cnt_q;
        acc_d       = (state_q == DIRECT) & w_acc;
        w_win_clr   = 1'b0;
        w_win_inc   = 1'b0;
        w_fl_clr    = 1'b0;
        w_fl_load   = 1'b0;
        w_fl_val    = '0;
        w_fl_dec    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start && (i_frame_len != '0)) begin
                    frame_len_d = i_frame_len;
                    sym_cnt_d   = '0;
                    cl3_d       = (i_constr_len == CL3);
                    state_d     = (i_mode_sel == MODE_DECODE) ? BMPRE : ENC;
                end
            end
            ENC: begin
                if (w_last) state_d = DONE;
            end
            BMPRE: begin
                if (i_cal_done) state_d = cl3_q ? DIRECT : FILL;
            end
            FILL: begin
                w_win_inc = w_acc;
                if (w_last) begin
                    state_d   = FLUSH;
                    w_fl_load = 1'b1;
                    w_fl_val  = w_win_cnt + TB_CW'(1);
                end else if (w_acc && w_win_term) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (w_last) begin
                    state_d   = FLUSH;
                    w_fl_load = 1'b1;
                    w_fl_val  = TB_CW'(TB_DEPTH);
                end
            end
            FLUSH: begin
                w_fl_dec = i_out_ready;
                if (i_out_ready && w_fl_term) state_d = DONE;
            end
            DIRECT: begin
                // All symbols in: this is the lagging output-bit cycle
                if (w_all_in) state_d = DONE;
            end
            DONE: begin
                state_d     = IDLE;
                sym_cnt_d   = '0;
                frame_len_d = '0;
                w_win_clr   = 1'b1;
                w_fl_clr    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (w_abort) begin
            state_d     = IDLE;
            sym_cnt_d   = '0;
            frame_len_d = '0;
            acc_d       = 1'b0;
            w_win_clr   = 1'b1;
            w_fl_clr    = 1'b1;
        end
    end

    // Unit enables and status pulses decoded from the current state
    always_comb begin
        o_en_ce  = 1'b0;
        o_en_s   = 1'b0;
        o_en_bm  = 1'b0;
        o_en_acs = 1'b0;
        o_en_td  = 1'b0;
        o_en_t   = 1'b0;
        o_done   = 1'b0;
        o_err    = 1'b0;
        if (w_run) begin
            case (state_q)
                IDLE:   o_err = i_start & (i_frame_len == '0);
                ENC:    o_en_ce = w_acc;
                BMPRE: begin
                    o_en_ce = 1'b1;
                    o_en_bm = 1'b1;
                end
                FILL: begin
                    o_en_s   = w_acc;
                    o_en_bm  = w_acc;
                    o_en_acs = w_acc;
                    o_en_td  = w_acc;
                end
                STREAM: begin
                    o_en_s   = w_acc;
                    o_en_bm  = w_acc;
                    o_en_acs = w_acc;
                    o_en_td  = w_acc;
                    o_en_t   = w_acc;
                end
                FLUSH: begin
                    o_en_td = 1'b1;
                    o_en_t  = i_out_ready;
                end
                DIRECT: begin
                    o_en_s   = w_acc;
                    o_en_bm  = w_acc;
                    o_en_acs = w_acc;
                    o_en_t   = acc_q;
                end
                DONE:    o_done = 1'b1;
                default: ;
            endcase
        end
    end

    assign o_in_ready = w_in_ready;
    assign o_busy     = en & (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_viterbi_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_viterbi_seq_ctrl
//  Description : Self-checking bench for viterbi_seq_ctrl. A count-based
//                frame model (symbols accepted, bits emitted) predicts every
//                output each cycle under random valid/ready/enable traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_viterbi_seq_ctrl;
    import viterbi_pkg::*;

    localparam int TB     = 8;
    localparam int FW     = 16;
    localparam int BUDGET = 1000;

    logic          clk = 1'b0;
    logic          rst, en, i_mode_sel, i_start, i_in_valid, i_cal_done, i_out_ready;
    logic [1:0]    i_constr_len;
    logic [FW-1:0] i_frame_len;
`ifdef VITERBI_ABORT_EN
    logic          i_abort;
`endif
    logic o_in_ready, o_en_ce, o_en_s, o_en_bm, o_en_acs, o_en_td, o_en_t;
    logic o_busy, o_done, o_err;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    viterbi_seq_ctrl #(.TB_DEPTH(TB), .FRAME_W(FW)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .i_constr_len (i_constr_len),
        .i_mode_sel   (i_mode_sel),
        .i_start      (i_start),
        .i_frame_len  (i_frame_len),
        .i_in_valid   (i_in_valid),
        .i_cal_done   (i_cal_done),
        .i_out_ready  (i_out_ready),
`ifdef VITERBI_ABORT_EN
        .i_abort      (i_abort),
`endif
        .o_in_ready   (o_in_ready),
        .o_en_ce      (o_en_ce),
        .o_en_s       (o_en_s),
        .o_en_bm      (o_en_bm),
        .o_en_acs     (o_en_acs),
        .o_en_td      (o_en_td),
        .o_en_t       (o_en_t),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {in_ready, ce, s, bm, acs, td, t, busy, done, err}
    function automatic logic [9:0] outv();
        return {o_in_ready, o_en_ce, o_en_s, o_en_bm, o_en_acs, o_en_td, o_en_t,
                o_busy, o_done, o_err};
    endfunction

    // cut_kind: 0 none, 1 reset, 2 abort; applied once acc_n >= cut_acc
    task automatic run_frame(input string name, input bit dec, input logic [1:0] cl,
                             input int len, input int pv, input int pr, input int pe,
                             input int cal_dly, input int stall_from, input int stall_len,
                             input int cut_kind, input int cut_acc);
        int acc_n, out_n, cyc, n_t, n_ce, n_done;
        bit cal_seen, prev_acc, fin, cut, is3, acc;
        bit e_rdy, e_ce, e_s, e_bm, e_acs, e_td, e_t, e_busy, e_done;
        acc_n = 0; out_n = 0; cyc = 0; n_t = 0; n_ce = 0; n_done = 0;
        cal_seen = 0; prev_acc = 0; fin = 0; cut = 0;
        is3 = dec && (cl == CL3);

        i_mode_sel = dec; i_constr_len = cl; i_frame_len = 16'(len);
        i_start = 1; en = 1; i_in_valid = 0; i_out_ready = 0; i_cal_done = 0;
        @(negedge clk);
        check_eq({name, "_start"}, 32'(outv()), {31'b0, (len == 0)});
        @(posedge clk); #1;
        i_start = 0;

        while (len != 0 && !fin && cyc < BUDGET) begin
            en          = ($urandom_range(99) < pe);
            i_in_valid  = ($urandom_range(99) < pv);
            i_out_ready = (cyc >= stall_from && cyc < stall_from + stall_len) ? 1'b0
                          : ($urandom_range(99) < pr);
            i_cal_done  = (cyc >= cal_dly);
            i_start     = ($urandom_range(7) == 0);
            cut = (cut_kind != 0) && (!dec || cal_seen) && (acc_n >= cut_acc);
            if (cut) begin
                en = 1;
                i_in_valid = 0;
                if (cut_kind == 1) rst = 0;
`ifdef VITERBI_ABORT_EN
                if (cut_kind == 2) i_abort = 1;
`endif
            end

            {e_rdy, e_ce, e_s, e_bm, e_acs, e_td, e_t, e_busy, e_done} = '0;
            acc = 0;
            if (en) begin
                e_busy = 1;
                if (!dec) begin
                    if (acc_n < len) begin
                        e_rdy = i_out_ready;
                        acc   = e_rdy & i_in_valid;
                        e_ce  = acc;
                    end else e_done = 1;
                end else if (!cal_seen) begin
                    e_ce = 1; e_bm = 1;
                end else if (acc_n < len) begin
                    e_rdy = is3 ? i_out_ready : ((acc_n < TB) ? 1'b1 : i_out_ready);
                    acc   = e_rdy & i_in_valid;
                    e_s = acc; e_bm = acc; e_acs = acc;
                    e_td = !is3 && acc;
                    e_t  = is3 ? prev_acc : (acc && acc_n >= TB);
                end else if (out_n < len) begin
                    e_t  = is3 ? 1'b1 : i_out_ready;
                    e_td = !is3;
                end else e_done = 1;
            end
            if (cut && cut_kind == 2) begin
                {e_rdy, e_ce, e_s, e_bm, e_acs, e_td, e_t, e_done} = '0;
                acc = 0;
            end

            @(negedge clk);
            if (!(cut && cut_kind == 1))
                check_eq({name, "_cyc"}, 32'(outv()),
                         32'({e_rdy, e_ce, e_s, e_bm, e_acs, e_td, e_t, e_busy, e_done, 1'b0}));
            n_t    += int'(o_en_t);
            n_ce   += int'(o_en_ce);
            n_done += int'(o_done);

            if (en && !cut) begin
                if (dec && !cal_seen) cal_seen = i_cal_done;
                else begin
                    acc_n += int'(acc);
                    out_n += int'(e_t);
                    prev_acc = is3 && acc;
                    if (e_done) fin = 1;
                end
            end
            @(posedge clk); #1;
            cyc++;
            if (cut) begin
                rst = 1;
`ifdef VITERBI_ABORT_EN
                i_abort = 0;
`endif
                fin = 1;
            end
        end

        if (len != 0 && !fin) begin
            check_eq({name, "_timeout"}, 32'd1, 32'd0);
            rst = 0;
            @(posedge clk); #1;
            rst = 1;
        end

        en = 1; i_start = 0; i_in_valid = 1; i_out_ready = 1; i_cal_done = 0;
        @(negedge clk);
        check_eq({name, "_idle"}, 32'(outv()), 32'd0);
        @(posedge clk); #1;

        if (len != 0) begin
            check_eq({name, "_done_cnt"}, n_done, (cut_kind == 0) ? 1 : 0);
            if (cut_kind == 0 && dec)  check_eq({name, "_bits"}, n_t, len);
            if (cut_kind == 0 && !dec) check_eq({name, "_ce"}, n_ce, len);
        end
    endtask

    initial begin
        rst = 0; en = 1; i_start = 0; i_in_valid = 0; i_cal_done = 0; i_out_ready = 0;
        i_mode_sel = MODE_ENCODE; i_constr_len = CL3; i_frame_len = '0;
`ifdef VITERBI_ABORT_EN
        i_abort = 0;
`endif
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("reset_state", 32'(outv()), 32'd0);
        @(posedge clk); #1;
        rst = 1;

        run_frame("dec_cl5_20", MODE_DECODE, CL5, 20, 100, 100, 100, 4, -1, 0, 0, 0);
        run_frame("enc_stall",  MODE_ENCODE, CL5, 4,  100, 100, 100, 0, 2, 2, 0, 0);
        run_frame("dec_cl3_5",  MODE_DECODE, CL3, 5,  100, 100, 100, 2, -1, 0, 0, 0);
        run_frame("dec_len3",   MODE_DECODE, CL7, 3,  100, 100, 100, 1, -1, 0, 0, 0);
        run_frame("dec_len_tb", MODE_DECODE, CL9, TB, 100, 100, 100, 0, -1, 0, 0, 0);
        run_frame("len_zero",   MODE_DECODE, CL5, 0,  100, 100, 100, 0, -1, 0, 0, 0);
        run_frame("rst_stream", MODE_DECODE, CL5, 20, 100, 100, 100, 1, -1, 0, 1, 10);
`ifdef VITERBI_ABORT_EN
        run_frame("abort_flush", MODE_DECODE, CL5, 20, 100, 100, 100, 2, -1, 0, 2, 20);
        run_frame("after_abort", MODE_DECODE, CL5, 10, 100, 100, 100, 2, -1, 0, 0, 0);
`endif
        for (int i = 0; i < 40; i++) begin
            run_frame("rnd", 1'($urandom_range(1)), 2'($urandom_range(3)),
                      int'($urandom_range(40, 1)), 70, 75, 90, int'($urandom_range(6)),
                      int'($urandom_range(30)), int'($urandom_range(3)), 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
